// File: rtl/serial_pkg.sv
// Shared definitions for both ends of the serial shift path, so that the
// serializer and the deserializer agree on word width and bit order.
package serial_pkg;

   localparam int DEFAULT_WIDTH = 4;

   typedef enum logic {
      LSB_FIRST = 1'b0,
      MSB_FIRST = 1'b1
   } bit_order_e;

   // Width of a counter that must hold the values 0..width.
   function automatic int cnt_w(input int width);
      return $clog2(width + 1);
   endfunction

endpackage

// File: rtl/sipo_deserializer_bit_counter.sv
// Modulo-MODULUS bit counter. o_wrap pulses on the increment that
// returns the count to zero.
module bit_counter
   import serial_pkg::*;
#(
   parameter int MODULUS = DEFAULT_WIDTH,
   parameter int CW      = cnt_w(MODULUS)
) (
   input  logic          clk,
   input  logic          reset,
   input  logic          i_clear,
   input  logic          i_inc,
   output logic [CW-1:0] o_cnt,
   output logic          o_wrap
);

   logic [CW-1:0] r_cnt;
   logic          w_last;

   assign w_last = (r_cnt == CW'(MODULUS - 1));
   assign o_wrap = i_inc && !i_clear && w_last;
   assign o_cnt  = r_cnt;

   // Clear takes priority over an increment in the same cycle.
   always_ff @(posedge clk) begin
      if (reset) begin
         r_cnt <= '0;
      end else if (i_clear) begin
         r_cnt <= '0;
      end else if (i_inc) begin
         r_cnt <= w_last ? '0 : r_cnt + 1'b1;
      end
   end

endmodule

// File: rtl/sipo_deserializer.sv
// Serial-in, parallel-out deserializer with a registered output word, a
// valid/ready handshake and a sticky overrun flag.
module sipo_deserializer #(
   parameter int WIDTH     = serial_pkg::DEFAULT_WIDTH,
   parameter bit MSB_FIRST = 1'b1
) (
   input  logic                                 clk,
   input  logic                                 reset,
   input  logic                                 sin,
   input  logic                                 shift,
   input  logic                                 clear,
   output logic [WIDTH-1:0]                     dout,
   output logic                                 dout_valid,
   input  logic                                 dout_ready,
   output logic                                 busy,
   output logic [serial_pkg::cnt_w(WIDTH)-1:0]  bit_cnt,
   output logic                                 overrun
);

   localparam serial_pkg::bit_order_e ORDER = serial_pkg::bit_order_e'(MSB_FIRST);
   localparam int CW = serial_pkg::cnt_w(WIDTH);

   logic [WIDTH-1:0] r_sreg;
   logic [WIDTH-1:0] r_dout;
   logic             r_valid;
   logic             r_overrun;
   logic [WIDTH-1:0] w_sreg_next;
   logic             w_wrap;
   logic [CW-1:0]    w_cnt;

   bit_counter #(
      .MODULUS (WIDTH),
      .CW      (CW)
   ) u_bit_counter (
      .clk     (clk),
      .reset   (reset),
      .i_clear (clear),
      .i_inc   (shift),
      .o_cnt   (w_cnt),
      .o_wrap  (w_wrap)
   );

   // The completing word includes the bit arriving on this edge.
   assign w_sreg_next = (ORDER == serial_pkg::MSB_FIRST) ? {r_sreg[WIDTH-2:0], sin}
                                                         : {sin, r_sreg[WIDTH-1:1]};

   // NOTE: all state is assigned with <= so every flop samples pre-edge values.
   always_ff @(posedge clk) begin
      if (reset) begin
         r_sreg    <= '0;
         r_dout    <= '0;
         r_valid   <= 1'b0;
         r_overrun <= 1'b0;
      end else begin
         if (clear) begin
            r_sreg <= '0;
         end else if (shift) begin
            r_sreg <= w_sreg_next;
         end

         if (w_wrap) begin
            r_dout  <= w_sreg_next;
            r_valid <= 1'b1;
            if (r_valid && !dout_ready) begin
               r_overrun <= 1'b1;
            end
         end else if (dout_ready) begin
            r_valid <= 1'b0;
         end
      end
   end

   assign dout       = r_dout;
   assign dout_valid = r_valid;
   assign overrun    = r_overrun;
   assign bit_cnt    = w_cnt;
   assign busy       = (w_cnt != '0);

endmodule

// File: doc/sipo_deserializer.md
Name: sipo_deserializer

Overview:
Serial-in, parallel-out deserializer: the receive end of the team's parallel-to-serial shift path. It collects WIDTH serial bits, qualified by a shift strobe, into a word. It presents each completed word on a registered parallel output with a valid/ready handshake. It sits on the receive side of a serial link, feeding a parallel consumer.

Parameters:
WIDTH, 4, word width in bits (>= 2)
MSB_FIRST, 1, 1 = first received bit lands in dout[WIDTH-1]; 0 = first bit lands in dout[0]

Ports:
clk  input  1  single clock, all logic on posedge
reset  input  1  synchronous, active-high reset
sin  input  1  serial data bit, sampled only when shift=1
shift  input  1  bit strobe; gaps between strobes allowed
clear  input  1  frame abort: discard partially assembled word
dout  output  WIDTH  completed parallel word (registered)
dout_valid  output  1  dout holds an unconsumed word
dout_ready  input  1  consumer accepts dout when dout_valid && dout_ready
busy  output  1  partial word in progress (bit_cnt != 0)
bit_cnt  output  $clog2(WIDTH+1)  bits collected in current word, 0..WIDTH-1
overrun  output  1  sticky: a completed word overwrote an unconsumed one

Behaviour:
- Reset (reset=1 at posedge): shift register, dout, bit_cnt, dout_valid, busy and overrun all go to 0. Reset overrides clear, shift and dout_ready. Reset mid-word discards the partial word.
- Shift register: on each posedge with shift=1 and clear=0:
  - MSB_FIRST=1: sreg <= {sreg[WIDTH-2:0], sin}.
  - MSB_FIRST=0: sreg <= {sin, sreg[WIDTH-1:1]}.
  - bit_cnt increments.
- Completion: a shift with bit_cnt==WIDTH-1 completes the word.
  - The same edge loads dout with the full word, including the current sin.
  - The same edge sets dout_valid=1 and wraps bit_cnt to 0.
  - Latency: dout/dout_valid are visible in the cycle after the WIDTH-th strobe.
  - Back-to-back words need no idle cycle; the next strobe starts bit 0 of the next word.
- Handshake:
  - dout_valid stays 1 and dout stays stable until a cycle with dout_ready=1.
  - After an accept, dout_valid clears on that edge, unless a completion occurs on the same edge.
  - dout_ready while dout_valid=0 has no effect.
- Simultaneous completion and accept: the new word loads, dout_valid stays 1, and overrun is unchanged.
- Completion while dout_valid=1 and dout_ready=0: the new word overwrites dout, dout_valid stays 1, and overrun sets to 1. overrun clears only on reset.
- clear=1:
  - bit_cnt <= 0 and sreg <= 0; any bit on sin that cycle is discarded, even if shift=1 (clear wins).
  - dout, dout_valid and overrun are not affected; a pending word survives clear.
- busy = (bit_cnt != 0), combinational from the registered count.
- No state machine beyond the counter: the counter plus dout_valid fully define state (IDLE = cnt 0, COLLECT = cnt>0, HOLD = dout_valid).

Decomposition:
- Shared package serial_pkg holds:
  - DEFAULT_WIDTH = 4.
  - bit_order_e enum {LSB_FIRST, MSB_FIRST}, shared with the parallel-to-serial side so both ends agree on order.
  - A count-width constant/function, clog2(WIDTH+1).
- No sub-module is required. Optionally factor out a wrapping counter, bit_counter (WIDTH modulus, clear, inc, wrap pulse).

Test Plan:
1. WIDTH=4, MSB_FIRST=1; reset 2 cycles, then shift bits 1,0,1,1 on consecutive cycles with dout_ready=0 -> the cycle after the 4th strobe shows dout=4'b1011 and dout_valid=1; bit_cnt steps 1,2,3,0; busy=0 afterwards.
2. Same stream with MSB_FIRST=0 -> dout=4'b1101.
3. Shift 1,0 with 3 idle cycles between strobes, then 0,1 -> dout=4'b1001; bit_cnt holds during the gaps.
4. Send word 4'b1010 (not accepted), then 4'b0110 with dout_ready=0 -> dout=4'b0110, overrun=1. Repeat from reset with dout_ready=1 on the completing edge of word 2 -> dout=4'b0110, dout_valid=1, overrun=0.
5. Shift 1,1 then clear=1 together with shift=1, sin=1; then shift 0,0,1,1 -> dout=4'b0011; a word pending before the clear remains unchanged.
6. Assert reset after 3 bits with dout_valid=1 -> the next cycle shows dout=0, dout_valid=0, bit_cnt=0, overrun=0; a fresh 4-bit word after reset is assembled correctly.
